victim_cache: RTL and testbench



---
 rtl/victim_cache_pkg.sv | 21 ++
 rtl/victim_cache_if.sv | 31 +++
 rtl/victim_cache_match.sv | 26 ++
 rtl/victim_cache.sv | 155 +++++++++++++++
 tb/tb_victim_cache.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/victim_cache_pkg.sv
// Shared types for the victim cache: per-line entry record and probe FSM states.
package victim_cache_pkg;

    localparam int VC_ENTRIES = 4;
    localparam int VC_TAG_W   = 26;
    localparam int VC_DATA_W  = 128;

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [VC_TAG_W-1:0]  tag;
        logic [VC_DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } vc_state_e;

endpackage

// File: rtl/victim_cache_if.sv
// L1-side probe/evict channels and memory-side writeback channel of the victim cache.
interface victim_cache_if #(
    parameter int TAG_W  = 26,
    parameter int DATA_W = 128
);
    logic              req_valid;
    logic              req_ready;
    logic [TAG_W-1:0]  req_tag;
    logic              resp_valid;
    logic              resp_hit;
    logic [DATA_W-1:0] resp_data;
    logic              evict_valid;
    logic              evict_ready;
    logic [TAG_W-1:0]  evict_tag;
    logic [DATA_W-1:0] evict_data;
    logic              evict_dirty;
    logic              wb_valid;
    logic              wb_ready;
    logic [TAG_W-1:0]  wb_tag;
    logic [DATA_W-1:0] wb_data;

    modport slave (
        input  req_valid, req_tag, evict_valid, evict_tag, evict_data, evict_dirty, wb_ready,
        output req_ready, resp_valid, resp_hit, resp_data, evict_ready, wb_valid, wb_tag, wb_data
    );

    modport master (
        output req_valid, req_tag, evict_valid, evict_tag, evict_data, evict_dirty, wb_ready,
        input  req_ready, resp_valid, resp_hit, resp_data, evict_ready, wb_valid, wb_tag, wb_data
    );
endinterface

// File: rtl/victim_cache_match.sv
// Parallel tag compare across all entries; tags are unique so the hit vector is one-hot.
module vc_match #(
    parameter int ENTRIES = 4,
    parameter int TAG_W   = 26,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0]            valid_i,
    input  logic [ENTRIES-1:0][TAG_W-1:0] tags_i,
    input  logic [TAG_W-1:0]              tag_i,
    output logic [ENTRIES-1:0]            hit_vec_o,
    output logic                          hit_o,
    output logic [IDX_W-1:0]              hit_idx_o
);
    for (genvar g = 0; g < ENTRIES; g++) begin : g_cmp
        assign hit_vec_o[g] = valid_i[g] && (tags_i[g] == tag_i);
    end

    assign hit_o = |hit_vec_o;

    // OR-encode is enough because at most one bit is set.
    always_comb begin
        hit_idx_o = '0;
        for (int i = 0; i < ENTRIES; i++)
            if (hit_vec_o[i]) hit_idx_o = hit_idx_o | IDX_W'(i);
    end
endmodule

// File: rtl/victim_cache.sv
// Fully-associative victim cache: 2-cycle probe FSM, single-cycle eviction insert,
// round-robin replacement with dirty writeback.
module victim_cache
    import victim_cache_pkg::*;
#(
    parameter int ENTRIES = VC_ENTRIES,
    parameter int TAG_W   = VC_TAG_W,   // must match the entry_t field widths
    parameter int DATA_W  = VC_DATA_W
) (
    input  logic          clk,
    input  logic          reset,
    victim_cache_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);

    vc_state_e                 state_q, state_d;
    entry_t [ENTRIES-1:0]      ent_q, ent_d;
    logic [IDX_W-1:0]          rr_q, rr_d;
    logic [TAG_W-1:0]          ptag_q, ptag_d;
    logic                      resp_valid_q, resp_valid_d;
    logic                      resp_hit_q, resp_hit_d;
    logic [DATA_W-1:0]         resp_data_q, resp_data_d;
    logic                      wb_valid_q, wb_valid_d;
    logic [TAG_W-1:0]          wb_tag_q, wb_tag_d;
    logic [DATA_W-1:0]         wb_data_q, wb_data_d;

    logic [ENTRIES-1:0]            vld;
    logic [ENTRIES-1:0][TAG_W-1:0] tags;
    logic [ENTRIES-1:0]            p_vec, e_vec;
    logic                          p_hit, e_hit, free_any;
    logic [IDX_W-1:0]              p_idx, e_idx, free_idx;
    logic                          req_fire, ev_fire;
    entry_t                        new_ent;

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            vld[i]  = ent_q[i].valid;
            tags[i] = ent_q[i].tag;
        end
    end

    vc_match #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) u_probe_match (
        .valid_i(vld), .tags_i(tags), .tag_i(ptag_q),
        .hit_vec_o(p_vec), .hit_o(p_hit), .hit_idx_o(p_idx)
    );

    vc_match #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) u_evict_match (
        .valid_i(vld), .tags_i(tags), .tag_i(bus.evict_tag),
        .hit_vec_o(e_vec), .hit_o(e_hit), .hit_idx_o(e_idx)
    );

    // Lowest-index free slot wins.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!vld[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign bus.evict_ready = (state_q != LOOKUP) && !wb_valid_q;
    assign req_fire        = bus.req_valid && bus.req_ready;
    assign ev_fire         = bus.evict_valid && bus.evict_ready;

    assign new_ent = '{valid: 1'b1, dirty: bus.evict_dirty, tag: bus.evict_tag, data: bus.evict_data};

    always_comb begin
        state_d      = state_q;
        ent_d        = ent_q;
        rr_d         = rr_q;
        ptag_d       = ptag_q;
        resp_valid_d = 1'b0;
        resp_hit_d   = resp_hit_q;
        resp_data_d  = resp_data_q;
        wb_valid_d   = wb_valid_q;
        wb_tag_d     = wb_tag_q;
        wb_data_d    = wb_data_q;

        if (wb_valid_q && bus.wb_ready) wb_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    ptag_d  = bus.req_tag;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                resp_valid_d = 1'b1;
                resp_hit_d   = p_hit;
                resp_data_d  = p_hit ? ent_q[p_idx].data : '0;
                // A hit line migrates back to L1, which now owns its dirtiness.
                if (p_hit) ent_d[p_idx].valid = 1'b0;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Evictions are blocked in LOOKUP, so they never collide with the hit invalidate.
        if (ev_fire) begin
            if (e_hit) begin
                ent_d[e_idx].data  = bus.evict_data;
                ent_d[e_idx].dirty = ent_q[e_idx].dirty | bus.evict_dirty;
            end else if (free_any) begin
                ent_d[free_idx] = new_ent;
            end else begin
                if (ent_q[rr_q].dirty) begin
                    wb_valid_d = 1'b1;
                    wb_tag_d   = ent_q[rr_q].tag;
                    wb_data_d  = ent_q[rr_q].data;
                end
                ent_d[rr_q] = new_ent;
                rr_d        = rr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ent_q        <= '0;
            rr_q         <= '0;
            ptag_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_data_q  <= '0;
            wb_valid_q   <= 1'b0;
            wb_tag_q     <= '0;
            wb_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            ent_q        <= ent_d;
            rr_q         <= rr_d;
            ptag_q       <= ptag_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_data_q  <= resp_data_d;
            wb_valid_q   <= wb_valid_d;
            wb_tag_q     <= wb_tag_d;
            wb_data_q    <= wb_data_d;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_hit   = resp_hit_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.wb_valid   = wb_valid_q;
    assign bus.wb_tag     = wb_tag_q;
    assign bus.wb_data    = wb_data_q;
endmodule

// File: tb/tb_victim_cache.sv
// Directed bench for victim_cache: stimulus pushes expected responses/writebacks,
// a negedge monitor pops and compares them.
module tb_victim_cache;
    localparam int TW = 26;
    localparam int DW = 128;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    victim_cache_if #(.TAG_W(TW), .DATA_W(DW)) bus ();

    victim_cache #(.ENTRIES(4), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct { logic hit; logic [DW-1:0] data; } resp_t;
    typedef struct { logic [TW-1:0] tag; logic [DW-1:0] data; } wb_t;

    resp_t resp_q[$];
    wb_t   wb_q[$];
    int    due_q[$];
    int    n_chk = 0;
    int    n_err = 0;
    int    cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] dat(int t);
        logic [31:0] w;
        w = t;
        return {4{w}};
    endfunction

    task automatic checkw(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check1(string name, logic act, logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic checki(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.req_valid && bus.req_ready) due_q.push_back(cyc + 2);
            if (bus.resp_valid) begin
                if (resp_q.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL resp_unexpected: got resp_valid=1 expected none");
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    check1("resp_hit", bus.resp_hit, r.hit);
                    checkw("resp_data", bus.resp_data, r.data);
                    if (due_q.size() > 0) checki("resp_latency", cyc, due_q.pop_front());
                end
            end
            if (bus.wb_valid && bus.wb_ready) begin
                if (wb_q.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL wb_unexpected: got wb tag %0h expected none", bus.wb_tag);
                end else begin
                    wb_t w;
                    w = wb_q.pop_front();
                    checkw("wb_tag", DW'(bus.wb_tag), DW'(w.tag));
                    checkw("wb_data", bus.wb_data, w.data);
                end
            end
        end
    end

    task automatic wait_ready(bit need_req, bit need_ev);
        int t = 0;
        while (((need_req && !bus.req_ready) || (need_ev && !bus.evict_ready)) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) begin
            n_chk++; n_err++;
            $display("FAIL ready_timeout: got no ready expected ready within 50 cycles");
        end
    endtask

    task automatic lookup_tail();
        @(negedge clk);
        check1("req_ready_lookup", bus.req_ready, 1'b0);
        check1("evict_ready_lookup", bus.evict_ready, 1'b0);
        @(negedge clk);
        check1("req_ready_resp", bus.req_ready, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic probe(logic [TW-1:0] t, logic hit, logic [DW-1:0] d);
        wait_ready(1'b1, 1'b0);
        resp_q.push_back('{hit, d});
        bus.req_valid = 1'b1;
        bus.req_tag   = t;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lookup_tail();
    endtask

    task automatic evict(logic [TW-1:0] t, logic [DW-1:0] d, logic dirty);
        wait_ready(1'b0, 1'b1);
        bus.evict_valid = 1'b1;
        bus.evict_tag   = t;
        bus.evict_data  = d;
        bus.evict_dirty = dirty;
        @(posedge clk); #1;
        bus.evict_valid = 1'b0;
    endtask

    task automatic probe_evict(logic [TW-1:0] t, logic [DW-1:0] d, logic dirty);
        wait_ready(1'b1, 1'b1);
        resp_q.push_back('{1'b1, d});
        bus.req_valid   = 1'b1;
        bus.req_tag     = t;
        bus.evict_valid = 1'b1;
        bus.evict_tag   = t;
        bus.evict_data  = d;
        bus.evict_dirty = dirty;
        @(posedge clk); #1;
        bus.req_valid   = 1'b0;
        bus.evict_valid = 1'b0;
        lookup_tail();
    endtask

    task automatic check_idle(string tag);
        @(negedge clk);
        check1({tag, "_resp_valid"}, bus.resp_valid, 1'b0);
        check1({tag, "_resp_hit"}, bus.resp_hit, 1'b0);
        checkw({tag, "_resp_data"}, bus.resp_data, '0);
        check1({tag, "_wb_valid"}, bus.wb_valid, 1'b0);
        checkw({tag, "_wb_tag"}, DW'(bus.wb_tag), '0);
        checkw({tag, "_wb_data"}, bus.wb_data, '0);
        check1({tag, "_req_ready"}, bus.req_ready, 1'b1);
        check1({tag, "_evict_ready"}, bus.evict_ready, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [DW-1:0] a5, d33a, d33b;
        a5   = {16{8'hA5}};
        d33a = {16{8'h33}};
        d33b = {16{8'h5C}};

        reset           = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_tag     = '0;
        bus.evict_valid = 1'b0;
        bus.evict_tag   = '0;
        bus.evict_data  = '0;
        bus.evict_dirty = 1'b0;
        bus.wb_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_idle("reset");

        // Cold miss
        probe(26'h0000123, 1'b0, '0);

        // Insert, hit (migrates out), then miss
        evict(26'h10, a5, 1'b0);
        probe(26'h10, 1'b1, a5);
        probe(26'h10, 1'b0, '0);

        // Fill, then round-robin replacement
        evict(26'd1, dat(1), 1'b0);
        evict(26'd2, dat(2), 1'b1);
        evict(26'd3, dat(3), 1'b0);
        evict(26'd4, dat(4), 1'b0);
        evict(26'd5, dat(5), 1'b1);          // displaces tag 1 (clean), rr -> 1
        bus.wb_ready = 1'b0;
        wb_q.push_back('{26'd2, dat(2)});
        evict(26'd6, dat(6), 1'b0);          // displaces tag 2 (dirty), rr -> 2
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check1("wb_hold_valid", bus.wb_valid, 1'b1);
            checkw("wb_hold_tag", DW'(bus.wb_tag), DW'(26'd2));
            checkw("wb_hold_data", bus.wb_data, dat(2));
            check1("wb_hold_evict_ready", bus.evict_ready, 1'b0);
        end
        @(posedge clk); #1;
        bus.wb_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check1("wb_drop_after_hs", bus.wb_valid, 1'b0);
        @(posedge clk); #1;
        evict(26'd7, dat(7), 1'b0);          // displaces tag 3, rr -> 3
        evict(26'd8, dat(8), 1'b0);          // displaces tag 4, rr wraps -> 0
        wb_q.push_back('{26'd5, dat(5)});
        evict(26'd9, dat(9), 1'b0);          // displaces tag 5 (dirty) at entry 0, rr -> 1
        probe(26'd6, 1'b1, dat(6));
        probe(26'd1, 1'b0, '0);
        probe(26'd5, 1'b0, '0);

        // Same-cycle insert + probe, then duplicate-tag merge
        probe_evict(26'h33, d33a, 1'b1);
        evict(26'h33, d33a, 1'b1);           // free entry 1
        evict(26'h33, d33b, 1'b0);           // merge: data replaced, dirty kept
        wb_q.push_back('{26'h33, d33b});
        evict(26'h40, dat(64), 1'b0);        // full, rr=1 displaces merged 0x33
        probe(26'd9, 1'b1, dat(9));
        evict(26'd9, dat(9), 1'b0);          // reinstate into the freed slot

        // Reset while a writeback is pending
        bus.wb_ready = 1'b0;
        evict(26'd8, dat(8), 1'b1);          // entry 3 becomes dirty
        evict(26'h50, dat(80), 1'b0);        // displaces tag 7, rr -> 3
        evict(26'h51, dat(81), 1'b0);        // displaces dirty tag 8
        @(negedge clk);
        check1("wb_pending_before_reset", bus.wb_valid, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.wb_ready = 1'b1;
        check_idle("reset_wb");
        probe(26'd9, 1'b0, '0);
        probe(26'h51, 1'b0, '0);

        // Reset during LOOKUP: response must never appear
        evict(26'h60, dat(96), 1'b0);
        wait_ready(1'b1, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_tag   = 26'h60;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        due_q.delete();
        check_idle("reset_lookup");
        repeat (3) @(posedge clk);
        #1;
        probe(26'h60, 1'b0, '0);

        repeat (5) @(posedge clk);
        checki("resp_queue_drained", resp_q.size(), 0);
        checki("wb_queue_drained", wb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish by 200000");
        $fatal(1, "timeout");
    end
endmodule
